// File: rtl/bullet_hit_detector.sv
// bullet_hit_detector
//   Sits downstream of the player bullet block. While the bullet is flying it
//   maps the bullet grid position onto the alien fleet. If an alien is there
//   and still alive, the block kills it and returns a one-cycle hit pulse to
//   the bullet block. The block also keeps the score and the number of aliens
//   left, and flags when the wave is cleared.
//
//   Grid: x 0..31, y 0..15. Alien (r,c) sits at x = fleet_x + c*pitch and
//   y = fleet_y + r. Its alive bit is o_alive[r*N_COLS + c].
//
// Ports
//   i_clk_36MHz      system clock
//   i_reset          synchronous active-high reset; overrides every other input
//   i_enable         1 = detection runs; 0 = all state holds and pulses read 0
//   i_new_wave       pulse: revive every alien (score is kept)
//   i_bullet_flying  bullet in flight, from the bullet block
//   i_bullet_x/y     bullet grid position
//   i_fleet_x/y      grid position of alien (0,0)
//   o_hit            one-cycle kill pulse, to the bullet block i_hit input
//   o_alive          alive bitmap, bit r*N_COLS + c
//   o_aliens_left    number of set bits in o_alive
//   o_score          kills, saturating at all-ones
//   o_wave_cleared   one-cycle pulse, coincident with the hit that kills the last alien
//   state_dbg        current FSM state (0 ARMED, 1 CHECK, 2 HIT, 3 WAIT_CLR)
//
// Handshake: o_hit asserts for exactly one enabled cycle per killed alien.
//   After a kill the block ignores the bullet until i_bullet_flying has been
//   seen low, so one bullet kills at most one alien.
module bullet_hit_detector #(
  parameter int N_COLS         = 8,
  parameter int N_ROWS         = 4,
  parameter int COL_PITCH_LOG2 = 1,
  parameter int SCORE_W        = 10
) (
  input  logic                       i_clk_36MHz,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic                       i_new_wave,
  input  logic                       i_bullet_flying,
  input  logic [4:0]                 i_bullet_x,
  input  logic [3:0]                 i_bullet_y,
  input  logic [4:0]                 i_fleet_x,
  input  logic [3:0]                 i_fleet_y,
  output logic                       o_hit,
  output logic [N_ROWS*N_COLS-1:0]   o_alive,
  output logic [5:0]                 o_aliens_left,
  output logic [SCORE_W-1:0]         o_score,
  output logic                       o_wave_cleared,
  output logic [1:0]                 state_dbg
);

  localparam int N_CELLS = N_ROWS * N_COLS;
  localparam int IDX_W   = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam logic [4:0] PITCH_MASK = 5'((1 << COL_PITCH_LOG2) - 1);

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    CHECK    = 2'd1,
    HIT      = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx_q;
  logic [N_CELLS-1:0]   alive;
  logic [5:0]           left;
  logic [SCORE_W-1:0]   score;
  logic                 hit_q;
  logic                 wave_q;

  // Geometry. The subtractions are one bit wider than the operands, so the
  // top bit is the borrow: it is set when the bullet is left of or above the fleet.
  logic [5:0]       dx;
  logic [4:0]       dy;
  logic [4:0]       col;
  logic [3:0]       row;
  logic             cand_valid;
  logic [IDX_W-1:0] cand_idx;

  assign dx  = {1'b0, i_bullet_x} - {1'b0, i_fleet_x};
  assign dy  = {1'b0, i_bullet_y} - {1'b0, i_fleet_y};
  assign col = dx[4:0] >> COL_PITCH_LOG2;
  assign row = dy[3:0];

  // A bullet between two columns (non-zero low bits of dx) cannot hit anything.
  assign cand_valid = !dx[5] && !dy[4] &&
                      ((dx[4:0] & PITCH_MASK) == 5'd0) &&
                      (col < 5'(N_COLS)) && (row < 4'(N_ROWS));
  assign cand_idx   = IDX_W'(int'(row) * N_COLS + int'(col));

  always_ff @(posedge i_clk_36MHz) begin
    if (i_reset) begin
      state  <= ARMED;
      idx_q  <= '0;
      alive  <= '1;
      left   <= 6'(N_CELLS);
      score  <= '0;
      hit_q  <= 1'b0;
      wave_q <= 1'b0;
    end else if (i_enable) begin
      // The pulse flags drop after one enabled cycle unless the CHECK branch sets them again.
      hit_q  <= 1'b0;
      wave_q <= 1'b0;
      if (i_new_wave) begin
        // A new wave wins over a kill in the same cycle. The kill is dropped and the score does not change.
        alive <= '1;
        left  <= 6'(N_CELLS);
        state <= ARMED;
      end else begin
        case (state)
          ARMED: begin
            if (i_bullet_flying && cand_valid) begin
              idx_q <= cand_idx;
              state <= CHECK;
            end
          end
          CHECK: begin
            if (!i_bullet_flying) begin
              // The bullet ended (top of screen or another event) before it was resolved.
              state <= ARMED;
            end else if (alive[idx_q] && (left != 6'd0)) begin
              alive[idx_q] <= 1'b0;
              left         <= left - 6'd1;
              if (score != {SCORE_W{1'b1}}) score <= score + SCORE_W'(1);
              hit_q  <= 1'b1;
              wave_q <= (left == 6'd1);
              state  <= HIT;
            end else begin
              state <= ARMED;
            end
          end
          HIT: begin
            state <= WAIT_CLR;
          end
          WAIT_CLR: begin
            if (!i_bullet_flying) state <= ARMED;
          end
          default: state <= ARMED;
        endcase
      end
    end
  end

  // While the block is disabled it holds its state, and the pulses read low.
  assign o_hit          = hit_q & i_enable;
  assign o_wave_cleared = wave_q & i_enable;
  assign o_alive        = alive;
  assign o_aliens_left  = left;
  assign o_score        = score;
  assign state_dbg      = state;

endmodule

// File: tb/tb_bullet_hit_detector.sv
module tb_bullet_hit_detector;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic       new_wave = 1'b0;
  logic       flying = 1'b0;
  logic [4:0] bullet_x = '0;
  logic [3:0] bullet_y = '0;
  logic [4:0] fleet_x = '0;
  logic [3:0] fleet_y = '0;
  logic       hit;
  logic [31:0] alive;
  logic [5:0] aliens_left;
  logic [9:0] score;
  logic       wave_cleared;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // Behavioural model of the fleet.
  bit alive_m[32];
  int left_m;
  int score_m;
  logic [9:0] exp_q[$];

  bullet_hit_detector dut (
    .i_clk_36MHz    (clk),
    .i_reset        (reset),
    .i_enable       (enable),
    .i_new_wave     (new_wave),
    .i_bullet_flying(flying),
    .i_bullet_x     (bullet_x),
    .i_bullet_y     (bullet_y),
    .i_fleet_x      (fleet_x),
    .i_fleet_y      (fleet_y),
    .o_hit          (hit),
    .o_alive        (alive),
    .o_aliens_left  (aliens_left),
    .o_score        (score),
    .o_wave_cleared (wave_cleared),
    .state_dbg      (state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns the alien index under the bullet, or -1 if no alien is there.
  // Uses the grid rules: pitch 2, 8 columns, 4 rows.
  function automatic int target(int bx, int by, int fx, int fy);
    int dx, dy;
    if (bx < fx || by < fy) return -1;
    dx = bx - fx;
    dy = by - fy;
    if (dx % 2 != 0) return -1;
    if (dx / 2 >= 8 || dy >= 4) return -1;
    return dy * 8 + dx / 2;
  endfunction

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = alive_m[i];
    return v;
  endfunction

  task automatic model_restore();
    for (int i = 0; i < 32; i++) alive_m[i] = 1'b1;
    left_m = 32;
  endtask

  task automatic pulse_new_wave();
    new_wave = 1'b1;
    step();
    new_wave = 1'b0;
    model_restore();
  endtask

  // Driver: the bullet flies at (bx,by) for n_on cycles and is then parked for 2 cycles.
  task automatic fly(input int bx, input int by, input int n_on,
                     output int hits, output int wcs, output int wc_with_hit);
    hits = 0; wcs = 0; wc_with_hit = 0;
    bullet_x = 5'(bx);
    bullet_y = 4'(by);
    flying = 1'b1;
    for (int k = 0; k < n_on + 2; k++) begin
      if (k == n_on) flying = 1'b0;
      step();
      hits += int'(hit);
      wcs  += int'(wave_cleared);
      if (hit && wave_cleared) wc_with_hit++;
    end
  endtask

  task automatic test_reset();
    enable = 1'b1; flying = 1'b1; new_wave = 1'b1;
    fleet_x = 5'd4; fleet_y = 4'd2; bullet_x = 5'd4; bullet_y = 4'd2;
    reset = 1'b1;
    step();
    reset = 1'b0; new_wave = 1'b0; flying = 1'b0;
    model_restore();
    score_m = 0;
    checks += 6;
    if (alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_alive: got %h expected ffffffff", alive); end
    if (aliens_left !== 6'd32) begin failures++; $display("FAIL reset_left: got %0d expected 32", aliens_left); end
    if (score !== 10'd0) begin failures++; $display("FAIL reset_score: got %0d expected 0", score); end
    if (hit !== 1'b0) begin failures++; $display("FAIL reset_hit: got %b expected 0", hit); end
    if (wave_cleared !== 1'b0) begin failures++; $display("FAIL reset_wave: got %b expected 0", wave_cleared); end
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
  endtask

  task automatic test_first_hit();
    fleet_x = 5'd4; fleet_y = 4'd2;
    bullet_x = 5'd4; bullet_y = 4'd2;
    flying = 1'b1;
    step();
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL first_hit_early: got %b expected 0", hit); end
    step();
    alive_m[0] = 1'b0; left_m--; score_m++;
    checks += 5;
    if (hit !== 1'b1) begin failures++; $display("FAIL first_hit_latency: got %b expected 1", hit); end
    if (wave_cleared !== 1'b0) begin failures++; $display("FAIL first_hit_wave: got %b expected 0", wave_cleared); end
    if (alive !== model_vec()) begin failures++; $display("FAIL first_hit_alive: got %h expected %h", alive, model_vec()); end
    if (score !== 10'(score_m)) begin failures++; $display("FAIL first_hit_score: got %0d expected %0d", score, score_m); end
    if (aliens_left !== 6'(left_m)) begin failures++; $display("FAIL first_hit_left: got %0d expected %0d", aliens_left, left_m); end
    step();
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL first_hit_width: got %b expected 0", hit); end
  endtask

  task automatic test_hold_no_rehit();
    int hits, wcs, both;
    hits = 0;
    repeat (20) begin step(); hits += int'(hit); end
    checks++;
    if (hits != 0) begin failures++; $display("FAIL hold_rehit: got %0d hits expected 0", hits); end
    flying = 1'b0;
    repeat (2) step();
    fly(4, 2, 6, hits, wcs, both);
    checks += 2;
    if (hits != 0) begin failures++; $display("FAIL dead_refly_hit: got %0d hits expected 0", hits); end
    if (score !== 10'(score_m)) begin failures++; $display("FAIL dead_refly_score: got %0d expected %0d", score, score_m); end
  endtask

  task automatic test_misses();
    int xs[3] = '{5, 3, 20};
    int ys[3] = '{3, 2, 2};
    int hits, wcs, both;
    for (int i = 0; i < 3; i++) begin
      fly(xs[i], ys[i], 6, hits, wcs, both);
      checks++;
      if (hits != 0) begin failures++; $display("FAIL miss_%0d_%0d: got %0d hits expected 0", xs[i], ys[i], hits); end
    end
    // Parked bullet on top of a live alien.
    bullet_x = 5'd6; bullet_y = 4'd2; flying = 1'b0;
    hits = 0;
    repeat (6) begin step(); hits += int'(hit); end
    checks += 2;
    if (hits != 0) begin failures++; $display("FAIL parked_hit: got %0d hits expected 0", hits); end
    if (alive !== model_vec()) begin failures++; $display("FAIL miss_alive: got %h expected %h", alive, model_vec()); end
  endtask

  task automatic test_clear_wave();
    int hits, wcs, both, tot_hits, early_wcs;
    pulse_new_wave();
    fleet_x = 5'd4; fleet_y = 4'd2;
    tot_hits = 0; early_wcs = 0;
    for (int idx = 0; idx < 32; idx++) begin
      fly(4 + 2 * (idx % 8), 2 + idx / 8, 4, hits, wcs, both);
      tot_hits += hits;
      alive_m[idx] = 1'b0; left_m--; score_m++;
      if (idx < 31) early_wcs += wcs;
      else begin
        checks += 2;
        if (wcs != 1) begin failures++; $display("FAIL clear_wave_pulses: got %0d expected 1", wcs); end
        if (both != 1) begin failures++; $display("FAIL clear_wave_with_hit: got %0d expected 1", both); end
      end
    end
    checks += 5;
    if (early_wcs != 0) begin failures++; $display("FAIL clear_wave_early: got %0d expected 0", early_wcs); end
    if (tot_hits != 32) begin failures++; $display("FAIL clear_hits: got %0d expected 32", tot_hits); end
    if (aliens_left !== 6'd0) begin failures++; $display("FAIL clear_left: got %0d expected 0", aliens_left); end
    if (alive !== 32'h0) begin failures++; $display("FAIL clear_alive: got %h expected 0", alive); end
    if (score !== 10'(score_m)) begin failures++; $display("FAIL clear_score: got %0d expected %0d", score, score_m); end
    pulse_new_wave();
    checks += 3;
    if (alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL new_wave_alive: got %h expected ffffffff", alive); end
    if (aliens_left !== 6'd32) begin failures++; $display("FAIL new_wave_left: got %0d expected 32", aliens_left); end
    if (score !== 10'(score_m)) begin failures++; $display("FAIL new_wave_score: got %0d expected %0d", score, score_m); end
  endtask

  task automatic test_new_wave_in_check();
    int hits;
    fleet_x = 5'd4; fleet_y = 4'd2;
    bullet_x = 5'd10; bullet_y = 4'd3;
    flying = 1'b1;
    step();
    checks++;
    if (state_dbg !== 2'd1) begin failures++; $display("FAIL nw_check_state: got %0d expected 1", state_dbg); end
    new_wave = 1'b1;
    step();
    new_wave = 1'b0;
    flying = 1'b0;
    model_restore();
    checks += 4;
    if (hit !== 1'b0) begin failures++; $display("FAIL nw_check_hit: got %b expected 0", hit); end
    if (alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL nw_check_alive: got %h expected ffffffff", alive); end
    if (score !== 10'(score_m)) begin failures++; $display("FAIL nw_check_score: got %0d expected %0d", score, score_m); end
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL nw_check_armed: got %0d expected 0", state_dbg); end
    hits = 0;
    repeat (3) begin step(); hits += int'(hit); end
    checks++;
    if (hits != 0) begin failures++; $display("FAIL nw_check_late_hit: got %0d expected 0", hits); end
  endtask

  task automatic test_random();
    int hits, wcs, both, fx, fy, bx, by, t, exp_hits, exp_wcs;
    logic [9:0] exp_score;
    for (int n = 0; n < 60; n++) begin
      fx = $urandom_range(0, 12);
      fy = $urandom_range(0, 11);
      bx = fx + $urandom_range(0, 17);
      by = fy + $urandom_range(0, 4);
      if ($urandom_range(0, 7) == 0 && fx > 0) bx = fx - 1;
      if ($urandom_range(0, 7) == 0 && fy > 0) by = fy - 1;
      fleet_x = 5'(fx); fleet_y = 4'(fy);
      t = target(bx, by, fx, fy);
      exp_hits = 0; exp_wcs = 0;
      if (t >= 0 && alive_m[t]) begin
        alive_m[t] = 1'b0; left_m--; score_m++;
        exp_hits = 1;
        if (left_m == 0) exp_wcs = 1;
      end
      exp_q.push_back(10'(score_m));
      fly(bx, by, $urandom_range(3, 8), hits, wcs, both);
      exp_score = exp_q.pop_front();
      checks += 5;
      if (hits != exp_hits) begin failures++; $display("FAIL rand_hits n=%0d b=(%0d,%0d) f=(%0d,%0d): got %0d expected %0d", n, bx, by, fx, fy, hits, exp_hits); end
      if (wcs != exp_wcs) begin failures++; $display("FAIL rand_wave n=%0d: got %0d expected %0d", n, wcs, exp_wcs); end
      if (alive !== model_vec()) begin failures++; $display("FAIL rand_alive n=%0d: got %h expected %h", n, alive, model_vec()); end
      if (aliens_left !== 6'(left_m)) begin failures++; $display("FAIL rand_left n=%0d: got %0d expected %0d", n, aliens_left, left_m); end
      if (score !== exp_score) begin failures++; $display("FAIL rand_score n=%0d: got %0d expected %0d", n, score, exp_score); end
      if (left_m == 0) pulse_new_wave();
    end
  endtask

  task automatic test_enable_and_reset();
    pulse_new_wave();
    fleet_x = 5'd4; fleet_y = 4'd2;
    bullet_x = 5'd6; bullet_y = 4'd2;
    flying = 1'b1;
    step();
    enable = 1'b0;
    repeat (3) begin
      step();
      checks += 3;
      if (hit !== 1'b0) begin failures++; $display("FAIL hold_hit: got %b expected 0", hit); end
      if (state_dbg !== 2'd1) begin failures++; $display("FAIL hold_state: got %0d expected 1", state_dbg); end
      if (alive[1] !== 1'b1) begin failures++; $display("FAIL hold_alive: got %b expected 1", alive[1]); end
    end
    enable = 1'b1;
    step();
    alive_m[1] = 1'b0; left_m--; score_m++;
    checks += 2;
    if (hit !== 1'b1) begin failures++; $display("FAIL resume_hit: got %b expected 1", hit); end
    if (alive !== model_vec()) begin failures++; $display("FAIL resume_alive: got %h expected %h", alive, model_vec()); end
    // Reset while in HIT with enable low.
    enable = 1'b0;
    #1;
    checks++;
    if (hit !== 1'b0) begin failures++; $display("FAIL disabled_hit: got %b expected 0", hit); end
    reset = 1'b1;
    step();
    reset = 1'b0; enable = 1'b1;
    model_restore(); score_m = 0;
    #1;
    checks += 5;
    if (hit !== 1'b0) begin failures++; $display("FAIL rst_hit_hit: got %b expected 0", hit); end
    if (alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_hit_alive: got %h expected ffffffff", alive); end
    if (aliens_left !== 6'd32) begin failures++; $display("FAIL rst_hit_left: got %0d expected 32", aliens_left); end
    if (score !== 10'd0) begin failures++; $display("FAIL rst_hit_score: got %0d expected 0", score); end
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_hit_state: got %0d expected 0", state_dbg); end
    // Drive to WAIT_CLR with the bullet still flying, then reset with enable toggling.
    repeat (3) step();
    step();
    checks++;
    if (state_dbg !== 2'd3) begin failures++; $display("FAIL reach_wait_clr: got %0d expected 3", state_dbg); end
    enable = 1'b0;
    step();
    enable = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    flying = 1'b0;
    checks += 4;
    if (wave_cleared !== 1'b0) begin failures++; $display("FAIL rst_wait_wave: got %b expected 0", wave_cleared); end
    if (alive !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_wait_alive: got %h expected ffffffff", alive); end
    if (score !== 10'd0) begin failures++; $display("FAIL rst_wait_score: got %0d expected 0", score); end
    if (state_dbg !== 2'd0) begin failures++; $display("FAIL rst_wait_state: got %0d expected 0", state_dbg); end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_hold_no_rehit();
    test_misses();
    test_clear_wave();
    test_new_wave_in_check();
    test_random();
    test_enable_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
